cp0_unit: RTL and testbench

- Coprocessor-0 for the multi-cycle MIPS core.
- Sits directly downstream of the main controller. It consumes EXLSet, EXLClr, CP0_Wr and CP0_Dst, and it produces IntReq back to the controller's interrupt state.
- Holds SR, Cause, EPC and PrID. Samples device interrupt lines and returns EPC to the PC path for ERET.

---
 rtl/cp0_unit_if.sv | 25 ++
 rtl/cp0_unit.sv | 131 +++++++++++++
 tb/tb_cp0_unit.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/cp0_unit_if.sv
// Bus between the main controller and coprocessor 0.
// The controller drives the master side and cp0_unit sits on the slave side.
interface cp0_unit_if;
  logic [4:0]  A;
  logic [31:0] DIn;
  logic [31:0] PC;
  logic [5:0]  HWInt;
  logic        We;
  logic        EPCDst;
  logic        EXLSet;
  logic        EXLClr;
  logic        IntReq;
  logic [31:0] EPC;
  logic [31:0] DOut;

  modport master (
    output A, DIn, PC, HWInt, We, EPCDst, EXLSet, EXLClr,
    input  IntReq, EPC, DOut
  );

  modport slave (
    input  A, DIn, PC, HWInt, We, EPCDst, EXLSet, EXLClr,
    output IntReq, EPC, DOut
  );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor 0 for the multi-cycle MIPS core: SR, Cause, EPC, PrID and interrupt request.
// Define CP0_TIMER_EN to add the Count/Compare timer, which feeds IP[15].
module cp0_unit #(
  parameter logic [31:0] PRID_VAL = 32'h0000_3000,
  parameter int          HW_LINES = 6
) (
  input logic        clk,
  input logic        reset,
  cp0_unit_if.slave  bus
);

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_SR      = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;

  logic [HW_LINES-1:0] im;
  logic [HW_LINES-1:0] ip;
  logic                exl;
  logic                ie;
  logic [31:0]         epc;
  logic [HW_LINES-1:0] ip_next;

  logic sw_write;
  logic wr_sr;
  logic wr_epc_sw;
  logic wr_epc_hw;

  // PC[1:0] is discarded because EPC is always word aligned.
  logic unused_pc_low;
  assign unused_pc_low = &{1'b0, bus.PC[1:0]};

  assign sw_write  = bus.We && !bus.EPCDst;
  assign wr_sr     = sw_write && (bus.A == REG_SR);
  assign wr_epc_sw = sw_write && (bus.A == REG_EPC);
  assign wr_epc_hw = bus.We && bus.EPCDst;

`ifdef CP0_TIMER_EN
  logic [31:0] count;
  logic [31:0] compare;
  logic        ti;
  logic        wr_count;
  logic        wr_compare;

  assign wr_count   = sw_write && (bus.A == REG_COUNT);
  assign wr_compare = sw_write && (bus.A == REG_COMPARE);

  // A software write to Count suppresses the match for that cycle; writing Compare acknowledges TI.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= 32'h0;
      compare <= 32'h0;
      ti      <= 1'b0;
    end else begin
      if (wr_count)
        count <= bus.DIn;
      else
        count <= count + 32'd1;
      if (wr_compare)
        compare <= bus.DIn;
      if (wr_compare)
        ti <= 1'b0;
      else if (!wr_count && (count == compare))
        ti <= 1'b1;
    end
  end

  assign ip_next = {bus.HWInt[HW_LINES-1] | ti, bus.HWInt[HW_LINES-2:0]};
`else
  assign ip_next = bus.HWInt;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im  <= '0;
      ie  <= 1'b0;
      exl <= 1'b0;
    end else begin
      if (wr_sr) begin
        im <= bus.DIn[15:10];
        ie <= bus.DIn[0];
      end
      // The exception strobes override any EXL value carried in an MTC0.
      if (bus.EXLSet)
        exl <= 1'b1;
      else if (bus.EXLClr)
        exl <= 1'b0;
      else if (wr_sr)
        exl <= bus.DIn[1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      epc <= 32'h0;
    else if (wr_epc_hw)
      epc <= {bus.PC[31:2], 2'b00};
    else if (wr_epc_sw)
      epc <= {bus.DIn[31:2], 2'b00};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ip <= '0;
    else
      ip <= ip_next;
  end

  assign bus.IntReq = !reset && (|(ip & im)) && ie && !exl;
  assign bus.EPC    = epc;

  always_comb begin
    bus.DOut = 32'h0;
    if (!reset) begin
      case (bus.A)
        REG_SR:    bus.DOut = {16'h0, im, 8'h0, exl, ie};
        REG_CAUSE: bus.DOut = {16'h0, ip, 10'h0};
        REG_EPC:   bus.DOut = epc;
        REG_PRID:  bus.DOut = PRID_VAL;
`ifdef CP0_TIMER_EN
        REG_COUNT:   bus.DOut = count;
        REG_COMPARE: bus.DOut = compare;
`endif
        default:   bus.DOut = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed test of cp0_unit: stimulus pushes expected values into a queue,
// and a monitor on the falling clock edge pops and compares them.
module tb_cp0_unit;

  logic clk = 1'b0;
  logic reset;

  cp0_unit_if bus ();

  cp0_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  chk_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Monitor: sel 0 = IntReq, 1 = EPC, 2 = DOut.
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        chk_t        c;
        logic [31:0] act;
        c = q.pop_front();
        case (c.sel)
          0:       act = {31'h0, bus.IntReq};
          1:       act = bus.EPC;
          default: act = bus.DOut;
        endcase
        checks++;
        if (act !== c.exp) begin
          failures++;
          $display("FAIL %s: got %08h expected %08h", c.name, act, c.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
    bus.We     = 1'b0;
    bus.EPCDst = 1'b0;
    bus.EXLSet = 1'b0;
    bus.EXLClr = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data,
                      input logic set, input logic clr);
    bus.A      = addr;
    bus.DIn    = data;
    bus.We     = 1'b1;
    bus.EPCDst = 1'b0;
    bus.EXLSet = set;
    bus.EXLClr = clr;
    drive_edge();
  endtask

  task automatic check_int(input string name, input logic exp);
    q.push_back('{name, 0, {31'h0, exp}});
    settle();
  endtask

  task automatic check_epc(input string name, input logic [31:0] exp);
    q.push_back('{name, 1, exp});
    settle();
  endtask

  task automatic check_dout(input string name, input logic [4:0] addr, input logic [31:0] exp);
    bus.A = addr;
    q.push_back('{name, 2, exp});
    settle();
  endtask

  initial begin
    reset      = 1'b1;
    bus.A      = 5'd0;
    bus.DIn    = 32'h0;
    bus.PC     = 32'h0;
    bus.HWInt  = 6'b0;
    bus.We     = 1'b0;
    bus.EPCDst = 1'b0;
    bus.EXLSet = 1'b0;
    bus.EXLClr = 1'b0;

    check_int("rst_intreq", 1'b0);
    check_epc("rst_epc", 32'h0);
    check_dout("rst_dout_prid", 5'd15, 32'h0);
    reset = 1'b0;
    check_dout("prid", 5'd15, 32'h0000_3000);
    check_dout("rst_sr", 5'd12, 32'h0);

    mtc0(5'd12, 32'h0000_FC01, 1'b0, 1'b0);
    check_dout("sr_write", 5'd12, 32'h0000_FC01);
    check_int("no_ip", 1'b0);

    bus.HWInt = 6'b000100;
    drive_edge();
    check_int("ip_intreq", 1'b1);
    check_dout("cause_ip12", 5'd13, 32'h0000_1000);

    bus.PC     = 32'h0000_3047;
    bus.We     = 1'b1;
    bus.EPCDst = 1'b1;
    bus.EXLSet = 1'b1;
    drive_edge();
    check_int("entry_intreq", 1'b0);
    check_epc("entry_epc", 32'h0000_3044);
    check_dout("entry_sr", 5'd12, 32'h0000_FC03);

    bus.EXLClr = 1'b1;
    drive_edge();
    check_int("eret_reassert", 1'b1);
    check_dout("eret_sr", 5'd12, 32'h0000_FC01);

    bus.EXLSet = 1'b1;
    drive_edge();
    check_int("reenter", 1'b0);
    bus.HWInt = 6'b0;
    drive_edge();
    bus.EXLClr = 1'b1;
    drive_edge();
    check_int("eret_no_pending", 1'b0);

    bus.HWInt = 6'b100001;
    mtc0(5'd13, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check_dout("cause_ro", 5'd13, 32'h0000_8400);
    check_int("ip15_ip10", 1'b1);
    mtc0(5'd15, 32'h1234_5678, 1'b0, 1'b0);
    check_dout("prid_ro", 5'd15, 32'h0000_3000);
    mtc0(5'd7, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check_dout("unmapped", 5'd7, 32'h0);
`ifndef CP0_TIMER_EN
    mtc0(5'd9, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check_dout("count_absent", 5'd9, 32'h0);
`endif

    mtc0(5'd12, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check_dout("sr_mask", 5'd12, 32'h0000_FC03);
    check_int("exl_blocks", 1'b0);

    mtc0(5'd12, 32'h0000_8403, 1'b0, 1'b1);
    check_dout("sr_wr_clr", 5'd12, 32'h0000_8401);
    check_int("sr_wr_clr_int", 1'b1);

    mtc0(5'd12, 32'h0, 1'b1, 1'b0);
    check_dout("sr_wr_set", 5'd12, 32'h0000_0002);
    check_int("sr_wr_set_int", 1'b0);

    mtc0(5'd12, 32'h0, 1'b0, 1'b1);
    check_dout("sr_clear", 5'd12, 32'h0);
    bus.EXLSet = 1'b1;
    bus.EXLClr = 1'b1;
    drive_edge();
    check_dout("set_beats_clr", 5'd12, 32'h0000_0002);

    mtc0(5'd14, 32'hABCD_EF13, 1'b0, 1'b0);
    check_epc("epc_sw", 32'hABCD_EF10);
    check_dout("epc_read", 5'd14, 32'hABCD_EF10);

    mtc0(5'd12, 32'h0000_FC01, 1'b0, 1'b1);
    check_int("pre_rst_int", 1'b1);
    bus.PC     = 32'h0000_4000;
    bus.We     = 1'b1;
    bus.EPCDst = 1'b1;
    bus.EXLSet = 1'b1;
    #2;
    reset = 1'b1;
    check_epc("rst_mid_epc", 32'h0);
    check_int("rst_mid_int", 1'b0);
    bus.We     = 1'b0;
    bus.EPCDst = 1'b0;
    bus.EXLSet = 1'b0;
    reset      = 1'b0;
    check_dout("rst_mid_sr", 5'd12, 32'h0);
    check_epc("rst_mid_epc_after", 32'h0);

    settle();
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
